// File: rtl/cache_controller.sv
// Read-only sequencing FSM for a direct-mapped 1024x4-word cache datapath.
// Miss handling fetches a whole line from memory one word per handshake.
module cache_controller #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_read,
    output logic              cache_write,
    output logic [DATA_W-1:0] cache_d1,
    output logic [DATA_W-1:0] cache_d2,
    output logic [DATA_W-1:0] cache_d3,
    output logic [DATA_W-1:0] cache_d4,
    input  logic [DATA_W-1:0] cache_data,
    input  logic              cache_hm,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  access_count,
    output logic [CNT_W-1:0]  hit_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FETCH,
        FILL,
        DONE
    } state_t;

    state_t            state_q;
    logic [1:0]        beat_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] cpu_data_q;
    logic [DATA_W-1:0] buf_q [4];
    logic [CNT_W-1:0]  acc_q;
    logic [CNT_W-1:0]  hit_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            req_addr_q <= '0;
            cpu_data_q <= '0;
            acc_q      <= '0;
            hit_q      <= '0;
            for (int i = 0; i < 4; i++) buf_q[i] <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        req_addr_q <= cpu_addr;
                        if (acc_q != '1) acc_q <= acc_q + CNT_W'(1);
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (cache_hm) begin
                        cpu_data_q <= cache_data;
                        if (hit_q != '1) hit_q <= hit_q + CNT_W'(1);
                        state_q <= DONE;
                    end else begin
                        beat_q  <= '0;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    // A stalled memory simply holds the current beat.
                    if (mem_ready) begin
                        buf_q[beat_q] <= mem_data;
                        beat_q        <= beat_q + 2'd1;
                        if (beat_q == 2'd3) state_q <= FILL;
                    end
                end
                FILL: begin
                    cpu_data_q <= buf_q[req_addr_q[1:0]];
                    state_q    <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = (state_q != IDLE);
    assign cpu_ready    = (state_q == DONE);
    assign cache_read   = (state_q == LOOKUP);
    assign cache_write  = (state_q == FILL);
    assign mem_read     = (state_q == FETCH);
    assign cpu_data     = cpu_data_q;
    assign cache_addr   = req_addr_q;
    assign mem_addr     = {req_addr_q[ADDR_W-1:2], beat_q};
    assign cache_d1     = buf_q[0];
    assign cache_d2     = buf_q[1];
    assign cache_d3     = buf_q[2];
    assign cache_d4     = buf_q[3];
    assign access_count = acc_q;
    assign hit_count    = hit_q;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural datapath and
// memory; a second, narrow-counter instance exercises saturation.
module tb_cache_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cpu_req;
    logic [14:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        cpu_ready, busy;
    logic [14:0] cache_addr;
    logic        cache_read, cache_write;
    logic [31:0] cache_d1, cache_d2, cache_d3, cache_d4;
    logic [31:0] cache_data;
    logic        cache_hm;
    logic        mem_read;
    logic [14:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready = 1'b0;
    logic [15:0] access_count, hit_count;

    cache_controller dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_data(cpu_data), .cpu_ready(cpu_ready), .busy(busy),
        .cache_addr(cache_addr), .cache_read(cache_read),
        .cache_write(cache_write),
        .cache_d1(cache_d1), .cache_d2(cache_d2),
        .cache_d3(cache_d3), .cache_d4(cache_d4),
        .cache_data(cache_data), .cache_hm(cache_hm),
        .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_ready(mem_ready),
        .access_count(access_count), .hit_count(hit_count)
    );

    // Narrow-counter instance with an always-hit datapath
    logic        req2;
    logic [14:0] addr2;
    logic [31:0] data2, d1_2, d2_2, d3_2, d4_2;
    logic        rdy2, busy2, crd2, cwr2, mrd2;
    logic [14:0] caddr2, maddr2;
    logic [1:0]  acc2, hit2;

    cache_controller #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .cpu_req(req2), .cpu_addr(addr2),
        .cpu_data(data2), .cpu_ready(rdy2), .busy(busy2),
        .cache_addr(caddr2), .cache_read(crd2), .cache_write(cwr2),
        .cache_d1(d1_2), .cache_d2(d2_2), .cache_d3(d3_2), .cache_d4(d4_2),
        .cache_data(32'h5A), .cache_hm(1'b1),
        .mem_read(mrd2), .mem_addr(maddr2),
        .mem_data(32'h0), .mem_ready(1'b0),
        .access_count(acc2), .hit_count(hit2)
    );

    // Behavioural datapath
    bit          dp_v   [1024];
    logic [2:0]  dp_tag [1024];
    logic [31:0] dp_data[1024][4];

    assign cache_hm   = dp_v[cache_addr[11:2]] &&
                        (dp_tag[cache_addr[11:2]] == cache_addr[14:12]);
    assign cache_data = dp_data[cache_addr[11:2]][cache_addr[1:0]];

    always @(posedge clk) begin
        if (cache_write) begin
            dp_v[cache_addr[11:2]]       <= 1'b1;
            dp_tag[cache_addr[11:2]]     <= cache_addr[14:12];
            dp_data[cache_addr[11:2]][0] <= cache_d1;
            dp_data[cache_addr[11:2]][1] <= cache_d2;
            dp_data[cache_addr[11:2]][2] <= cache_d3;
            dp_data[cache_addr[11:2]][3] <= cache_d4;
        end
    end

    // Memory: word value depends on tag and word offset
    function automatic logic [31:0] memval(input logic [14:0] a);
        return 32'hA0 + 32'(a[14:12]) * 32'h10 + 32'(a[1:0]);
    endfunction

    assign mem_data = memval(mem_addr);

    int   stall_n = 0;
    int   scnt    = 0;
    logic mr_tie  = 1'b0;

    always @(posedge clk) begin
        if (mem_read && mem_ready) scnt = 0;
        else if (mem_read)         scnt = scnt + 1;
        else                       scnt = 0;
    end

    always @(negedge clk)
        mem_ready = mr_tie || (mem_read && (scnt >= stall_n));

    // Observers: memory handshakes and line writes
    logic [14:0] mem_q[$];
    int          wr_count = 0;
    logic [31:0] wr_d[4];

    always @(posedge clk) begin
        if (mem_read && mem_ready) mem_q.push_back(mem_addr);
        if (cache_write) begin
            wr_count = wr_count + 1;
            wr_d[0]  = cache_d1;
            wr_d[1]  = cache_d2;
            wr_d[2]  = cache_d3;
            wr_d[3]  = cache_d4;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Issue one request from IDLE; lat is the cycle of cpu_ready
    task automatic req(input logic [14:0] a, input bit noisy,
                       output int lat, output logic [31:0] d);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = a;
        lat      = -1;
        d        = '0;
        for (int k = 1; k < 200; k++) begin
            @(negedge clk);
            if (noisy) begin
                cpu_req  = k[0];
                cpu_addr = 15'($urandom);
            end else begin
                cpu_req = 1'b0;
            end
            if (cpu_ready) begin
                lat = k;
                d   = cpu_data;
                break;
            end
        end
        cpu_req = 1'b0;
    endtask

    typedef struct {
        logic [14:0] addr;
        int          stall;
        bit          tie;
        bit          noisy;
        int          lat;
        logic [31:0] data;
        int          acc;
        int          hit;
    } vec_t;

    vec_t        v[8];
    int          lat, w0;
    logic [31:0] d;

    initial begin
        v[0] = '{15'h0005, 0, 1'b1, 1'b0,  7, 32'hA1, 1, 0};
        v[1] = '{15'h0007, 0, 1'b1, 1'b0,  2, 32'hA3, 2, 1};
        v[2] = '{15'h1005, 0, 1'b1, 1'b0,  7, 32'hB1, 3, 1};
        v[3] = '{15'h0005, 0, 1'b0, 1'b0,  7, 32'hA1, 4, 1};
        v[4] = '{15'h0006, 0, 1'b0, 1'b0,  2, 32'hA2, 5, 2};
        v[5] = '{15'h2013, 3, 1'b0, 1'b0, 19, 32'hC3, 6, 2};
        v[6] = '{15'h2010, 0, 1'b0, 1'b0,  2, 32'hC0, 7, 3};
        v[7] = '{15'h3001, 2, 1'b0, 1'b1, 15, 32'hD1, 8, 3};

        rst      = 1'b0;
        cpu_req  = 1'b0;
        cpu_addr = '0;
        req2     = 1'b0;
        addr2    = '0;
        repeat (3) @(negedge clk);

        chk("rst busy",  32'(busy), 0);
        chk("rst ready", 32'(cpu_ready), 0);
        chk("rst rd",    32'(cache_read), 0);
        chk("rst wr",    32'(cache_write), 0);
        chk("rst mrd",   32'(mem_read), 0);
        chk("rst data",  cpu_data, 0);
        chk("rst d1-4",  cache_d1 | cache_d2 | cache_d3 | cache_d4, 0);
        chk("rst acc",   32'(access_count), 0);
        chk("rst hit",   32'(hit_count), 0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            stall_n = v[i].stall;
            mr_tie  = v[i].tie;
            mem_q.delete();
            w0 = wr_count;
            req(v[i].addr, v[i].noisy, lat, d);
            chk($sformatf("v%0d lat", i),  32'(lat), 32'(v[i].lat));
            chk($sformatf("v%0d data", i), d, v[i].data);
            chk($sformatf("v%0d acc", i),  32'(access_count), 32'(v[i].acc));
            chk($sformatf("v%0d hit", i),  32'(hit_count), 32'(v[i].hit));
            if (v[i].lat != 2) begin
                chk($sformatf("v%0d beats", i), 32'(mem_q.size()), 4);
                if (mem_q.size() == 4)
                    for (int k = 0; k < 4; k++)
                        chk($sformatf("v%0d maddr%0d", i, k), 32'(mem_q[k]),
                            32'({v[i].addr[14:2], 2'(k)}));
                chk($sformatf("v%0d wr", i), 32'(wr_count), 32'(w0 + 1));
                for (int k = 0; k < 4; k++)
                    chk($sformatf("v%0d buf%0d", i, k), wr_d[k],
                        memval({v[i].addr[14:2], 2'(k)}));
            end else begin
                chk($sformatf("v%0d beats", i), 32'(mem_q.size()), 0);
                chk($sformatf("v%0d wr", i), 32'(wr_count), 32'(w0));
            end
        end

        // Reset in the middle of a line fetch
        mr_tie  = 1'b0;
        stall_n = 0;
        mem_q.delete();
        w0 = wr_count;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 15'h0009;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            if (mem_q.size() >= 2) break;
        end
        chk("mid beats", 32'(mem_q.size()), 2);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid busy", 32'(busy), 0);
        chk("mid acc",  32'(access_count), 0);
        chk("mid hit",  32'(hit_count), 0);
        chk("mid d1",   cache_d1, 0);
        chk("mid d2",   cache_d2, 0);
        repeat (3) @(negedge clk);
        chk("mid nowr", 32'(wr_count), 32'(w0));
        req(15'h0009, 1'b0, lat, d);
        chk("post lat",  32'(lat), 7);
        chk("post data", d, 32'hA1);
        chk("post acc",  32'(access_count), 1);
        chk("post hit",  32'(hit_count), 0);

        // Saturating 2-bit counters
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            req2  = 1'b1;
            addr2 = 15'(n);
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                req2 = 1'b0;
                if (rdy2) break;
            end
        end
        chk("sat hit",  32'(hit2), 3);
        chk("sat acc",  32'(acc2), 3);
        chk("sat data", data2, 32'h5A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequencing FSM for the direct-mapped 1024-line, 4-word-per-line instruction/data cache datapath (15-bit word address: tag[14:12], index[11:2], word offset[1:0]).
- Accepts one CPU read request at a time and performs the tag lookup through the datapath.
- On a miss, fetches the full 4-word line from main memory one word per handshake, writes the line into the datapath, and returns the requested word.
- Counts accesses and hits for hit-rate measurement.

Parameters:
ADDR_W, 15, word address width (tag 3 + index 10 + offset 2)
DATA_W, 32, word width
CNT_W, 16, width of access/hit counters

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
cpu_req  in  1  read request, sampled only in IDLE
cpu_addr  in  ADDR_W  word address, latched on acceptance
cpu_data  out  DATA_W  returned word, valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
busy  out  1  1 whenever state != IDLE
cache_addr  out  ADDR_W  address to datapath (latched request address)
cache_read  out  1  datapath lookup enable
cache_write  out  1  datapath line-write enable
cache_d1..cache_d4  out  DATA_W each  line buffer words 0..3 to datapath D1..D4
cache_data  in  DATA_W  datapath read word (combinational)
cache_hm  in  1  datapath hit/miss (1 = hit, combinational)
mem_read  out  1  memory word request
mem_addr  out  ADDR_W  {tag, index, beat[1:0]}
mem_data  in  DATA_W  memory word
mem_ready  in  1  mem_data valid this cycle
access_count  out  CNT_W  accepted requests
hit_count  out  CNT_W  requests hit in LOOKUP

Behaviour:
- Reset (rst=0 at a rising edge): state IDLE; beat=0; cpu_data, cache_d1..d4, access_count, hit_count = 0; cpu_ready, cache_read, cache_write, mem_read, busy = 0. Reset overrides any in-progress operation; no cache_write is issued afterwards; the partially filled buffer is discarded.
- The datapath has its own reset; this block does not clear it.
- States: IDLE, LOOKUP, FETCH, FILL, DONE. All control outputs are decoded from registered state (Moore).
- IDLE: if cpu_req=1, latch cpu_addr into req_addr, access_count+1 (saturating), go LOOKUP. Otherwise stay.
- LOOKUP (1 cycle): cache_read=1, cache_addr=req_addr.
  - cache_hm=1 at the edge: cpu_data<=cache_data, hit_count+1 (saturating), go DONE.
  - cache_hm=0: beat<=0, go FETCH.
- FETCH: mem_read=1, mem_addr={req_addr[14:2], beat}.
  - On an edge with mem_ready=1: buffer word[beat]<=mem_data (beat 0→cache_d1 … beat 3→cache_d4), beat+1.
  - After the beat-3 capture, go FILL. mem_ready=0 holds state and beat indefinitely; there is no timeout.
- FILL (1 cycle): cache_write=1, cache_read=0, cache_addr=req_addr; cache_d1..d4 stable. cpu_data<=buffer word[req_addr[1:0]]. Go DONE.
- DONE (1 cycle): cpu_ready=1, cpu_data held. Go IDLE.
- cpu_data holds its last value until the next update. cache_addr drives req_addr in all states.
- Latency (cycle 0 = IDLE cycle with cpu_req=1):
  - Hit: cpu_ready in cycle 2.
  - Miss with mem_ready tied high: FETCH cycles 2–5, FILL cycle 6, cpu_ready in cycle 7. Each stalled beat adds one cycle.
- cpu_req and cpu_addr are ignored while busy (no queueing). With cpu_req held high, the next request is accepted in the IDLE cycle after DONE.
- mem_ready is ignored outside FETCH.
- Counters saturate at 2^CNT_W−1, with no wrap. Miss count = access_count − hit_count.
- Exactly one of cache_read and cache_write is active in LOOKUP and FILL respectively; both are 0 elsewhere.

Test Plan:
- Cold miss: reset, then request addr 0x0005; memory returns 0xA0,0xA1,0xA2,0xA3 for mem_addr 0x0004..0x0007 with mem_ready=1 → mem_addr sequence 0x0004–0x0007; cache_write in cycle 6 with d1..d4=A0..A3; cpu_ready in cycle 7 with cpu_data=0xA1; access=1, hit=0.
- Hit after fill: request 0x0007 → no mem_read; cpu_ready in cycle 2, cpu_data=0xA3; access=2, hit=1.
- Conflict miss: request 0x1005 (same index, tag 1); memory returns 0xB0–0xB3 → refill; cpu_data=0xB1. A following request to 0x0005 misses again (hit unchanged).
- Memory stall: mem_ready low for 3 cycles before each beat → beat/state held; cpu_ready in cycle 19; buffer contents correct.
- Reset mid-fetch: rst=0 after beat 1 → next cycle IDLE; counters 0; no cache_write pulse; a subsequent request to the same line still misses.
- Busy/saturation: cpu_req toggled and cpu_addr changed during FETCH → ignored, original address served. With CNT_W=2, 5 hits → hit_count=3.
